instr_decode_stage: RTL and testbench

- Registered decode stage of the 31-instruction MIPS core, sitting between instruction fetch and the control unit.
- Converts a raw 32-bit instruction word into the 32-bit one-hot decoded_instr vector the control unit consumes, plus the extracted register and immediate fields.
- Holds the result in a one-entry pipeline register with valid/ready handshakes on both sides, a flush input, and a saturating illegal-instruction counter.

---
 rtl/instr_decode_stage_if.sv | 36 +++
 rtl/instr_decode_stage.sv | 123 ++++++++++++
 tb/tb_instr_decode_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and control-side handshake bundle for the registered decode stage.
// The master modport is the surrounding pipeline; the slave modport is the decode stage.
interface instr_decode_stage_if #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [PC_W-1:0]   in_pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       decoded_instr;
   logic              illegal;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [15:0]       imm16;
   logic [25:0]       target26;
   logic [PC_W-1:0]   out_pc;
   logic [CNT_W-1:0]  illegal_cnt;

   modport master (
      output in_valid, instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, decoded_instr, illegal, rs, rt, rd, shamt,
             imm16, target26, out_pc, illegal_cnt
   );

   modport slave (
      input  in_valid, instr, in_pc, flush, out_ready,
      output in_ready, out_valid, decoded_instr, illegal, rs, rt, rd, shamt,
             imm16, target26, out_pc, illegal_cnt
   );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered MIPS decode stage: raw word -> one-hot instruction class plus fields,
// held in a one-entry valid/ready pipeline register with flush and illegal counting.
module instr_decode_stage #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_decode_stage_if.slave  bus
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
      OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
      OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
      OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B
   } opcode_e;

   typedef enum logic [5:0] {
      F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04,
      F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_ADD  = 6'h20,
      F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND  = 6'h24,
      F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A,
      F_SLTU = 6'h2B
   } funct_e;

   opcode_e           opcode;
   funct_e            funct;
   logic [31:0]       dec_d;
   logic              accept;

   logic              valid_q;
   logic [31:0]       dec_q;
   logic [31:0]       instr_q;
   logic [PC_W-1:0]   pc_q;
   logic [CNT_W-1:0]  cnt_q;

   assign opcode = opcode_e'(bus.instr[31:26]);
   assign funct  = funct_e'(bus.instr[5:0]);

   always_comb begin
      dec_d = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_ADD:   dec_d[0]  = 1'b1;
               F_ADDU:  dec_d[1]  = 1'b1;
               F_SUB:   dec_d[2]  = 1'b1;
               F_SUBU:  dec_d[3]  = 1'b1;
               F_AND:   dec_d[4]  = 1'b1;
               F_OR:    dec_d[5]  = 1'b1;
               F_XOR:   dec_d[6]  = 1'b1;
               F_NOR:   dec_d[7]  = 1'b1;
               F_SLT:   dec_d[8]  = 1'b1;
               F_SLTU:  dec_d[9]  = 1'b1;
               F_SLL:   dec_d[10] = 1'b1;
               F_SRL:   dec_d[11] = 1'b1;
               F_SRA:   dec_d[12] = 1'b1;
               F_SLLV:  dec_d[13] = 1'b1;
               F_SRLV:  dec_d[14] = 1'b1;
               F_SRAV:  dec_d[15] = 1'b1;
               F_JR:    dec_d[16] = 1'b1;
               default: dec_d[31] = 1'b1;
            endcase
         end
         OP_ADDI:  dec_d[17] = 1'b1;
         OP_ADDIU: dec_d[18] = 1'b1;
         OP_ANDI:  dec_d[19] = 1'b1;
         OP_ORI:   dec_d[20] = 1'b1;
         OP_XORI:  dec_d[21] = 1'b1;
         OP_LUI:   dec_d[22] = 1'b1;
         OP_LW:    dec_d[23] = 1'b1;
         OP_SW:    dec_d[24] = 1'b1;
         OP_BEQ:   dec_d[25] = 1'b1;
         OP_BNE:   dec_d[26] = 1'b1;
         OP_SLTI:  dec_d[27] = 1'b1;
         OP_SLTIU: dec_d[28] = 1'b1;
         OP_J:     dec_d[29] = 1'b1;
         OP_JAL:   dec_d[30] = 1'b1;
         default:  dec_d[31] = 1'b1;
      endcase
   end

   assign bus.in_ready = ~bus.flush & (~valid_q | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;

   // Flush blocks accept through in_ready, so the accept branch never fires alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         dec_q   <= '0;
         instr_q <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         dec_q   <= dec_d;
         instr_q <= bus.instr;
         pc_q    <= bus.in_pc;
         if (dec_d[31] && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Fields are sliced from the held word so they reset to zero with it.
   assign bus.out_valid     = valid_q;
   assign bus.decoded_instr = dec_q;
   assign bus.illegal       = dec_q[31];
   assign bus.rs            = instr_q[25:21];
   assign bus.rt            = instr_q[20:16];
   assign bus.rd            = instr_q[15:11];
   assign bus.shamt         = instr_q[10:6];
   assign bus.imm16         = instr_q[15:0];
   assign bus.target26      = instr_q[25:0];
   assign bus.out_pc        = pc_q;
   assign bus.illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode map, handshake, backpressure,
// flush, illegal counter saturation and reset priority.
module tb_instr_decode_stage;

   localparam int unsigned PC_W  = 32;
   localparam int unsigned CNT_W = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   instr_decode_stage_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   instr_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] word, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.instr    = word;
      bus.in_pc    = pc;
   endtask

   logic [31:0] vec_word [6];
   int          vec_bit  [6];

   initial begin
      vec_word[0] = 32'h10000000; vec_bit[0] = 25; // beq
      vec_word[1] = 32'h03E00008; vec_bit[1] = 16; // jr $31
      vec_word[2] = 32'hAC000000; vec_bit[2] = 24; // sw
      vec_word[3] = 32'h3C000000; vec_bit[3] = 22; // lui
      vec_word[4] = 32'h00000007; vec_bit[4] = 15; // srav
      vec_word[5] = 32'h2C000000; vec_bit[5] = 28; // sltiu

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.instr     = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_decoded", bus.decoded_instr, 32'h0);
      check("rst_cnt", 32'(bus.illegal_cnt), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_pc", bus.out_pc, 32'h0);
      check("rst_imm16", 32'(bus.imm16), 32'h0);

      // add $16,$17,$18
      drive(32'h02328020, 32'h0000_0100);
      tick();
      check("add_valid", 32'(bus.out_valid), 32'd1);
      check("add_dec", bus.decoded_instr, 32'h00000001);
      check("add_rs", 32'(bus.rs), 32'd17);
      check("add_rt", 32'(bus.rt), 32'd18);
      check("add_rd", 32'(bus.rd), 32'd16);
      check("add_pc", bus.out_pc, 32'h0000_0100);
      check("add_illegal", 32'(bus.illegal), 32'd0);

      // back-to-back lw then jal, one result per cycle
      drive(32'h8C880004, 32'h0000_0104);
      tick();
      check("lw_valid", 32'(bus.out_valid), 32'd1);
      check("lw_dec", bus.decoded_instr, 32'h00800000);
      check("lw_rs", 32'(bus.rs), 32'd4);
      check("lw_rt", 32'(bus.rt), 32'd8);
      check("lw_imm", 32'(bus.imm16), 32'h0004);
      drive(32'h0C100000, 32'h0000_0108);
      tick();
      check("jal_valid", 32'(bus.out_valid), 32'd1);
      check("jal_dec", bus.decoded_instr, 32'h40000000);
      check("jal_target", 32'(bus.target26), 32'h0100000);
      check("jal_pc", bus.out_pc, 32'h0000_0108);

      // backpressure: lw held, jal waiting
      drive(32'h8C880004, 32'h0000_0200);
      tick();
      bus.out_ready = 1'b0;
      drive(32'h0C100000, 32'h0000_0204);
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 32'(bus.out_valid), 32'd1);
         check("bp_dec", bus.decoded_instr, 32'h00800000);
         check("bp_pc", bus.out_pc, 32'h0000_0200);
         check("bp_in_ready_hold", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("bp_jal_dec", bus.decoded_instr, 32'h40000000);
      check("bp_jal_pc", bus.out_pc, 32'h0000_0204);

      // assorted decode map entries
      for (int i = 0; i < 6; i++) begin
         drive(vec_word[i], 32'(i));
         tick();
         check("map_dec", bus.decoded_instr, 32'h1 << vec_bit[i]);
      end

      // illegal words
      drive(32'hFC000000, 32'h0000_0300);
      tick();
      check("ill_op_dec", bus.decoded_instr, 32'h80000000);
      check("ill_op_flag", 32'(bus.illegal), 32'd1);
      check("ill_op_cnt", 32'(bus.illegal_cnt), 32'd1);
      drive(32'h0000003F, 32'h0000_0304);
      tick();
      check("ill_fn_dec", bus.decoded_instr, 32'h80000000);
      check("ill_fn_cnt", 32'(bus.illegal_cnt), 32'd2);

      // flush with a held result and an incoming illegal word
      bus.flush = 1'b1;
      drive(32'hFC000000, 32'h0000_0400);
      #1;
      check("flush_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("flush_valid", 32'(bus.out_valid), 32'd0);
      check("flush_cnt", 32'(bus.illegal_cnt), 32'd2);
      check("flush_pc_hold", bus.out_pc, 32'h0000_0304);
      bus.flush = 1'b0;

      // drain: consumed with nothing new arriving
      drive(32'h00000000, 32'h0000_0500);
      tick();
      check("sll_dec", bus.decoded_instr, 32'h00000400);
      bus.in_valid = 1'b0;
      tick();
      check("drain_valid", 32'(bus.out_valid), 32'd0);
      check("drain_dec_hold", bus.decoded_instr, 32'h00000400);

      // saturation: 2 + 260 illegal accepts clamps at 255
      for (int i = 0; i < 260; i++) begin
         drive(32'hFC000000, 32'(i));
         tick();
      end
      check("sat_cnt", 32'(bus.illegal_cnt), 32'd255);
      drive(32'h02328020, 32'h0000_0600);
      tick();
      check("sat_legal_cnt", 32'(bus.illegal_cnt), 32'd255);

      // reset wins over a simultaneous accept
      rst = 1'b1;
      drive(32'hFC000000, 32'h0000_0700);
      tick();
      check("rst2_valid", 32'(bus.out_valid), 32'd0);
      check("rst2_dec", bus.decoded_instr, 32'h0);
      check("rst2_cnt", 32'(bus.illegal_cnt), 32'd0);
      check("rst2_rs", 32'(bus.rs), 32'd0);
      check("rst2_target", 32'(bus.target26), 32'd0);
      check("rst2_pc", bus.out_pc, 32'h0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
